// File: rtl/alu_defs.sv
// Shared ALU definitions: op codes produced by ALUControl and the EX-stage
// output buffer state encoding.
package alu_defs;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_INV = 4'b1111;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_HEAD  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_ex_stage_core.sv
// Combinational ALU: computes result and flags for one op.
// Unknown op codes give result 0 with the illegal flag raised.
module alu_core
    import alu_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        ctrl_sig,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              illegal
);

    localparam int MSB = DATA_W - 1;

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [DATA_W-1:0] b_eff;
    logic signed [DATA_W-1:0] sum;
    logic                     is_sub;

    assign a_s    = a;
    assign b_s    = b;
    assign is_sub = (ctrl_sig == ALU_SUB);
    assign b_eff  = is_sub ? -b_s : b_s;
    assign sum    = a_s + b_eff;

    // SLT uses a true signed compare so it stays correct when a-b overflows.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (ctrl_sig)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD, ALU_SUB: begin
                result   = sum;
                overflow = (a_s[MSB] == b_eff[MSB]) && (sum[MSB] != a_s[MSB]);
            end
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            default: illegal = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_ex_stage.sv
// EX stage: ALU result registered into a 2-entry (head + skid) buffer
// with valid/ready on both sides and a registered in_ready.
module alu_ex_stage
    import alu_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ctrl_sig,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              reg_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              illegal,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write
);

    // Stage p0: combinational ALU on the incoming op
    logic [DATA_W-1:0] alu_result_p0;
    logic              alu_zero_p0;
    logic              alu_ovf_p0;
    logic              alu_ill_p0;
    logic              alu_we_p0;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .ctrl_sig (ctrl_sig),
        .a        (src_a),
        .b        (src_b),
        .result   (alu_result_p0),
        .zero     (alu_zero_p0),
        .overflow (alu_ovf_p0),
        .illegal  (alu_ill_p0)
    );

    assign alu_we_p0 = reg_write && !alu_ill_p0;

    // Handshake FSM
    buf_state_e state_q;
    buf_state_e state_d;
    logic       in_ready_q;
    logic       push;
    logic       pop;
    logic       load_head_new;
    logic       load_head_skid;
    logic       load_skid;

    assign push = in_valid && in_ready_q;
    assign pop  = (state_q != BUF_EMPTY) && out_ready;

    always_comb begin
        state_d        = state_q;
        load_head_new  = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        state_d       = BUF_HEAD;
                        load_head_new = 1'b1;
                    end
                end
                BUF_HEAD: begin
                    if (push && pop) begin
                        load_head_new = 1'b1;
                    end else if (push) begin
                        state_d   = BUF_FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        state_d        = BUF_HEAD;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    // in_ready is computed from the next state so it lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != BUF_FULL);
        end
    end

    // Stage p1: head (output) and skid registers
    logic [DATA_W-1:0] head_result_p1;
    logic              head_zero_p1;
    logic              head_ovf_p1;
    logic              head_ill_p1;
    logic [REG_AW-1:0] head_rd_p1;
    logic              head_we_p1;

    logic [DATA_W-1:0] skid_result_p1;
    logic              skid_zero_p1;
    logic              skid_ovf_p1;
    logic              skid_ill_p1;
    logic [REG_AW-1:0] skid_rd_p1;
    logic              skid_we_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_result_p1 <= '0;
            head_zero_p1   <= 1'b0;
            head_ovf_p1    <= 1'b0;
            head_ill_p1    <= 1'b0;
            head_rd_p1     <= '0;
            head_we_p1     <= 1'b0;
        end else if (load_head_new) begin
            head_result_p1 <= alu_result_p0;
            head_zero_p1   <= alu_zero_p0;
            head_ovf_p1    <= alu_ovf_p0;
            head_ill_p1    <= alu_ill_p0;
            head_rd_p1     <= rd_addr;
            head_we_p1     <= alu_we_p0;
        end else if (load_head_skid) begin
            head_result_p1 <= skid_result_p1;
            head_zero_p1   <= skid_zero_p1;
            head_ovf_p1    <= skid_ovf_p1;
            head_ill_p1    <= skid_ill_p1;
            head_rd_p1     <= skid_rd_p1;
            head_we_p1     <= skid_we_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_result_p1 <= alu_result_p0;
            skid_zero_p1   <= alu_zero_p0;
            skid_ovf_p1    <= alu_ovf_p0;
            skid_ill_p1    <= alu_ill_p0;
            skid_rd_p1     <= rd_addr;
            skid_we_p1     <= alu_we_p0;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != BUF_EMPTY);
    assign result        = head_result_p1;
    assign zero          = head_zero_p1;
    assign overflow      = head_ovf_p1;
    assign illegal       = head_ill_p1;
    assign out_rd_addr   = head_rd_p1;
    assign out_reg_write = head_we_p1;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: directed corner steps then a randomized
// valid/ready stream scored against a queue-based reference model.
module tb_alu_ex_stage;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        il;
        logic [4:0]  rd;
        logic        we;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ctrl_sig;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write;

    int     n_asserts = 0;
    int     n_fail    = 0;
    int     n_acc     = 0;
    entry_t q[$];

    alu_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ctrl_sig      (ctrl_sig),
        .src_a         (src_a),
        .src_b         (src_b),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .overflow      (overflow),
        .illegal       (illegal),
        .out_rd_addr   (out_rd_addr),
        .out_reg_write (out_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: ADD/SUB overflow is the a + b' sum leaving the signed 32-bit range.
    function automatic entry_t ref_alu(input logic [3:0] c, input logic [31:0] a,
                                       input logic [31:0] b, input logic [4:0] rd,
                                       input logic we);
        entry_t      e;
        longint      sa, sb, sbp, s;
        logic [31:0] bp;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = 32'd0; e.ov = 1'b0; e.il = 1'b0; e.rd = rd; e.we = we;
        case (c)
            OP_AND: e.res = a & b;
            OP_OR:  e.res = a | b;
            OP_ADD, OP_SUB: begin
                bp   = (c == OP_SUB) ? (~b + 32'd1) : b;
                sbp  = longint'($signed(bp));
                s    = sa + sbp;
                e.res = s[31:0];
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SLT: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: begin e.il = 1'b1; e.we = 1'b0; end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("result", result, q[0].res);
            chk("zero", zero, q[0].z);
            chk("overflow", overflow, q[0].ov);
            chk("illegal", illegal, q[0].il);
            chk("out_rd_addr", out_rd_addr, q[0].rd);
            chk("out_reg_write", out_reg_write, q[0].we);
        end
    endtask

    // Called at a falling edge: check, drive, update model, advance one cycle.
    task automatic step(input logic iv, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic we,
                        input logic ordy, input logic fl, input logic rs);
        bit push, pop;
        check_outputs();
        in_valid = iv; ctrl_sig = c; src_a = a; src_b = b; rd_addr = rd;
        reg_write = we; out_ready = ordy; flush = fl; rst = rs;
        push = iv && (q.size() < 2);
        pop  = (q.size() > 0) && ordy;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (pop) q.delete(0);
            if (push) begin
                q.push_back(ref_alu(c, a, b, rd, we));
                n_acc++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [3:0] codes [5];
        logic [3:0] c;
        int cyc;
        codes[0] = OP_AND; codes[1] = OP_OR; codes[2] = OP_ADD;
        codes[3] = OP_SUB; codes[4] = OP_SLT;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; ctrl_sig = 4'h0; src_a = '0;
        src_b = '0; rd_addr = '0; reg_write = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_rd", out_rd_addr, 5'd0);
        chk("rst_we", out_reg_write, 1'b0);

        // Directed arithmetic corner cases
        step(1, OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd3, 1, 1, 0, 0);
        chk("add_ovf_result", result, 32'h8000_0000);
        chk("add_ovf_flag", overflow, 1'b1);
        step(1, OP_SUB, 32'd5, 32'd5, 5'd4, 1, 1, 0, 0);
        chk("sub_zero_result", result, 32'h0);
        chk("sub_zero_flag", zero, 1'b1);
        chk("sub_zero_ovf", overflow, 1'b0);
        step(1, OP_SLT, 32'h8000_0000, 32'h1, 5'd5, 1, 1, 0, 0);
        chk("slt_neg_lt", result, 32'h1);
        step(1, OP_SLT, 32'h1, 32'h8000_0000, 5'd6, 1, 1, 0, 0);
        chk("slt_pos_ge", result, 32'h0);
        step(1, OP_AND, 32'hF0F0, 32'h0FF0, 5'd7, 1, 1, 0, 0);
        chk("and_result", result, 32'h00F0);
        step(1, OP_OR, 32'hF0F0, 32'h0FF0, 5'd8, 1, 1, 0, 0);
        chk("or_result", result, 32'hFFF0);
        step(1, 4'b1111, 32'h1234, 32'h5678, 5'd9, 1, 1, 0, 0);
        chk("inv_illegal", illegal, 1'b1);
        chk("inv_result", result, 32'h0);
        chk("inv_zero", zero, 1'b1);
        chk("inv_we", out_reg_write, 1'b0);
        step(0, OP_AND, 0, 0, 0, 0, 1, 0, 0);
        chk("drain_empty", out_valid, 1'b0);

        // Fill to FULL with the consumer stalled, then drain in order
        step(1, OP_ADD, 32'd1, 32'd2, 5'd1, 1, 0, 0, 0);
        step(1, OP_ADD, 32'd3, 32'd4, 5'd2, 1, 0, 0, 0);
        chk("full_in_ready", in_ready, 1'b0);
        step(1, OP_ADD, 32'd5, 32'd6, 5'd3, 1, 0, 0, 0);
        chk("full_hold_result", result, 32'd3);
        step(1, OP_ADD, 32'd5, 32'd6, 5'd3, 1, 1, 0, 0);
        chk("drain1_result", result, 32'd7);
        step(1, OP_ADD, 32'd5, 32'd6, 5'd3, 1, 1, 0, 0);
        chk("drain2_result", result, 32'd11);
        step(0, OP_AND, 0, 0, 0, 0, 1, 0, 0);
        chk("drain3_empty", out_valid, 1'b0);

        // Flush in FULL with in_valid high
        step(1, OP_ADD, 32'd10, 32'd1, 5'd1, 1, 0, 0, 0);
        step(1, OP_ADD, 32'd20, 32'd1, 5'd2, 1, 0, 0, 0);
        step(1, OP_ADD, 32'd30, 32'd1, 5'd3, 1, 0, 1, 0);
        chk("flush_full_valid", out_valid, 1'b0);
        chk("flush_full_ready", in_ready, 1'b1);
        step(0, OP_AND, 0, 0, 0, 0, 1, 0, 0);
        // Flush in HEAD beats a simultaneous transfer
        step(1, OP_ADD, 32'd40, 32'd1, 5'd4, 1, 0, 0, 0);
        step(1, OP_ADD, 32'd50, 32'd1, 5'd5, 1, 1, 1, 0);
        chk("flush_head_valid", out_valid, 1'b0);
        step(0, OP_AND, 0, 0, 0, 0, 1, 0, 0);

        // Reset mid-stream
        step(1, OP_ADD, 32'd60, 32'd1, 5'd6, 1, 0, 0, 0);
        step(1, OP_ADD, 32'd70, 32'd1, 5'd7, 1, 0, 0, 0);
        step(1, OP_ADD, 32'd80, 32'd1, 5'd8, 1, 0, 0, 1);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_we", out_reg_write, 1'b0);
        chk("midrst_result", result, 32'h0);

        // Random valid/ready stream
        n_acc = 0;
        cyc = 0;
        while (n_acc < 10000 && cyc < 40000) begin
            if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(0, 15));
            else c = codes[$urandom_range(0, 4)];
            step($urandom_range(0, 9) < 7, c, rand_opnd(), rand_opnd(),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 499) == 0, 1'b0);
            cyc++;
        end
        chk("random_ops_accepted", n_acc >= 10000, 1'b1);
        step(0, OP_AND, 0, 0, 0, 0, 1, 0, 0);
        step(0, OP_AND, 0, 0, 0, 0, 1, 0, 0);
        step(0, OP_AND, 0, 0, 0, 0, 1, 0, 0);
        chk("final_empty", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
